// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch unit. Requests a 16-bit word at pc, latches it
//            into IR, and presents the decoded fields to the control unit
//            until they are accepted. Stops permanently once a HALT
//            instruction is accepted.
// Options  : INSTR_FETCH_PERF_EN adds saturating cycle/instruction counters.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [15:0]       imem_rdata,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [3:0]        opcode,
    output logic [3:0]        rd,
    output logic [3:0]        rs1,
    output logic [3:0]        rs2_imm,
    input  logic              halt_in,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [15:0]       cyc_cnt,
    output logic [15:0]       instr_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;
    logic        fetch_done;
    logic        handshake;

    // Read data only counts while a request is outstanding; stray rvalid is dropped.
    assign fetch_done = (state == REQ) && imem_rvalid;
    assign handshake  = (state == ISSUE) && dec_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        dec_valid = 1'b0;
        halted    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_rvalid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                dec_valid = 1'b1;
                if (dec_ready) begin
                    state_nxt = halt_in ? HALTED : REQ;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Instruction register and program counter; pc wraps naturally at 2^ADDR_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= 16'h0000;
            pc <= RESET_PC;
        end else if (fetch_done) begin
            ir <= imem_rdata;
            pc <= pc + 1'b1;
        end
    end

    assign imem_addr = pc;
    assign opcode    = ir[15:12];
    assign rd        = ir[11:8];
    assign rs1       = ir[7:4];
    assign rs2_imm   = ir[3:0];

`ifdef INSTR_FETCH_PERF_EN
    // Busy-cycle counter: counts cycles spent fetching or issuing, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= 16'h0000;
        end else if (((state == REQ) || (state == ISSUE)) && (cyc_cnt != 16'hFFFF)) begin
            cyc_cnt <= cyc_cnt + 16'h0001;
        end
    end

    // Retired-instruction counter: counts accepted issues, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= 16'h0000;
        end else if (handshake && (instr_cnt != 16'hFFFF)) begin
            instr_cnt <= instr_cnt + 16'h0001;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch (RESET_PC = 8'hFF so the
//            first fetch also exercises pc wrap-around). Expected issues are
//            queued by the stimulus and checked by an independent monitor.
// Options  : INSTR_FETCH_PERF_EN enables the counter checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [7:0] C_RESET_PC = 8'hFF;

    typedef struct packed {
        logic [15:0] ir;
        logic [7:0]  pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2_imm;
    wire         halt_in;
    logic [7:0]  pc;
    logic        halted;
`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] cyc_cnt;
    logic [15:0] instr_cnt;
`endif

    int          n_cmp  = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    logic [15:0] mem [256];
    bit          mem_en = 1'b0;
    int          lat    = 0;
    int          wait_cnt = 0;

    instr_fetch #(
        .ADDR_W   (8),
        .RESET_PC (C_RESET_PC)
    ) dut (
        .clk         (clk),
`ifdef INSTR_FETCH_PERF_EN
        .cyc_cnt     (cyc_cnt),
        .instr_cnt   (instr_cnt),
`endif
        .rst_n       (rst_n),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .opcode      (opcode),
        .rd          (rd),
        .rs1         (rs1),
        .rs2_imm     (rs2_imm),
        .halt_in     (halt_in),
        .pc          (pc),
        .halted      (halted)
    );

    // Control unit stand-in: opcode F is HALT
    assign halt_in = (opcode == 4'hF);

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: answers a request after 'lat' wait cycles
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (!imem_req) begin
                wait_cnt = 0;
                if (mem_en) imem_rvalid = 1'b0;
            end else if (mem_en) begin
                if (wait_cnt >= lat) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem[imem_addr];
                    wait_cnt    = 0;
                end else begin
                    imem_rvalid = 1'b0;
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: every accepted issue must match the head of the expected queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && dec_valid && dec_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", {16'h0, opcode, rd, rs1, rs2_imm}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_ir", {16'h0, opcode, rd, rs1, rs2_imm}, {16'h0, e.ir});
                    chk("issue_pc", {24'h0, pc}, {24'h0, e.pc});
                end
            end
        end
    end

    task automatic wait_halted(input string name);
        int k = 0;
        while (!halted && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'h0, halted}, 32'h1);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'hFF] = 16'h1123;
        mem[8'h00] = 16'h2456;
        mem[8'h01] = 16'h5105;
        mem[8'h02] = 16'hF000;
        rst_n = 1'b0; start = 1'b0; dec_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pc",        {24'h0, pc}, {24'h0, C_RESET_PC});
        chk("rst_req_valid", {30'h0, imem_req, dec_valid}, 32'h0);
        chk("rst_halted",    {31'h0, halted}, 32'h0);
        chk("rst_ir",        {16'h0, opcode, rd, rs1, rs2_imm}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_req", {31'h0, imem_req}, 32'h0);

        // Stray rvalid in IDLE is ignored
        imem_rvalid = 1'b1; imem_rdata = 16'hDEAD;
        @(negedge clk);
        imem_rvalid = 1'b0;
        @(negedge clk);
        chk("stray_idle_pc", {24'h0, pc}, {24'h0, C_RESET_PC});
        chk("stray_idle_ir", {16'h0, opcode, rd, rs1, rs2_imm}, 32'h0);

        // First fetch at FF, zero-latency memory, ready downstream
        mem_en = 1'b1; lat = 0; dec_ready = 1'b1;
        exp_q.push_back('{ir: 16'h1123, pc: 8'h00});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("fetch1_req",  {31'h0, imem_req}, 32'h1);
        chk("fetch1_addr", {24'h0, imem_addr}, 32'hFF);
        @(negedge clk);
        chk("issue1_valid",  {31'h0, dec_valid}, 32'h1);
        chk("issue1_fields", {16'h0, opcode, rd, rs1, rs2_imm}, 32'h1123);
        @(negedge clk);
        chk("issue1_one_cycle", {31'h0, dec_valid}, 32'h0);
        chk("fetch2_req",  {31'h0, imem_req}, 32'h1);
        chk("fetch2_wrap", {24'h0, imem_addr}, 32'h00);

        // Downstream stalls for 5 cycles during the second issue
        dec_ready = 1'b0;
        exp_q.push_back('{ir: 16'h2456, pc: 8'h01});
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_valid",  {31'h0, dec_valid}, 32'h1);
            chk("stall_fields", {16'h0, opcode, rd, rs1, rs2_imm}, 32'h2456);
            chk("stall_no_req", {31'h0, imem_req}, 32'h0);
            chk("stall_pc",     {24'h0, pc}, 32'h01);
        end
        exp_q.push_back('{ir: 16'h5105, pc: 8'h02});
        exp_q.push_back('{ir: 16'hF000, pc: 8'h03});
        dec_ready = 1'b1;

        // Run to HALT, then confirm start has no effect
        wait_halted("halt_reached");
        chk("halt_pc",       {24'h0, pc}, 32'h03);
        chk("halt_pending",  exp_q.size(), 32'h0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_sticky", {29'h0, halted, imem_req, dec_valid}, 32'h4);
        end

        // Reset in the middle of a slow fetch; late rvalid afterwards
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lat = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("slow_req", {31'h0, imem_req}, 32'h1);
        @(negedge clk);
        mem_en = 1'b0; imem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", {31'h0, imem_req}, 32'h0);
        chk("async_rst_pc",  {24'h0, pc}, {24'h0, C_RESET_PC});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_rvalid = 1'b1; imem_rdata = 16'hDEAD;
        @(negedge clk);
        imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rvalid_idle", {30'h0, imem_req, dec_valid}, 32'h0);
            chk("late_rvalid_pc",   {24'h0, pc}, {24'h0, C_RESET_PC});
            chk("late_rvalid_ir",   {16'h0, opcode, rd, rs1, rs2_imm}, 32'h0);
        end

        // Three instructions back to back: 2 cycles each, then HALTED
        mem[8'hFF] = 16'h3210;
        mem[8'h00] = 16'h4321;
        mem[8'h01] = 16'hF000;
        mem_en = 1'b1; lat = 0; dec_ready = 1'b1;
`ifdef INSTR_FETCH_PERF_EN
        chk("perf_rst_cyc",   {16'h0, cyc_cnt}, 32'h0);
        chk("perf_rst_instr", {16'h0, instr_cnt}, 32'h0);
`endif
        exp_q.push_back('{ir: 16'h3210, pc: 8'h00});
        exp_q.push_back('{ir: 16'h4321, pc: 8'h01});
        exp_q.push_back('{ir: 16'hF000, pc: 8'h02});
        start = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            k++;
        end while (!halted && k < 100);
        chk("throughput_cycles", k, 32'd7);
        chk("burst_pc",      {24'h0, pc}, 32'h02);
        chk("burst_pending", exp_q.size(), 32'h0);
`ifdef INSTR_FETCH_PERF_EN
        chk("perf_cyc",   {16'h0, cyc_cnt}, 32'd6);
        chk("perf_instr", {16'h0, instr_cnt}, 32'd3);
`endif
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
